// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with 2-flop input sync and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          w_rx_s;
    logic          w_tick_end;
    logic          w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_perr;

    assign w_par_bad  = ^{r_shift, r_par};
    assign parity_err = r_perr;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rx};
    end

    assign w_rx_s     = r_sync[1];
    assign w_tick_end = (r_tick == TICK_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            if (rx_en) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= S_START;
                            r_tick  <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick == TICK_MID) begin
                            r_tick <= '0;
                            if (!w_rx_s) begin
                                r_state <= S_DATA;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_tick_end) begin
                            r_shift[r_bit] <= w_rx_s;
                            r_tick         <= '0;
                            r_bit          <= r_bit + 1'b1;
                            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_tick_end) begin
                            r_par   <= w_rx_s;
                            r_tick  <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        // Leave at mid-stop so a back-to-back start edge is seen
                        if (w_tick_end) begin
                            r_tick  <= '0;
                            r_state <= S_IDLE;
                            if (w_rx_s && !w_par_bad) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                            if (!w_rx_s) r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (w_par_bad) r_perr <= 1'b1;
`endif
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at OVERSAMPLE=16, rx_en every 4 clk.
// One bit period is 64 clk; the line is driven on the falling clock edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    logic [1:0] r_div = 2'd0;
    int         n_pass = 0;
    int         n_total = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] q_data[$];

    localparam int BIT_CLK = 64;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) r_div <= r_div + 2'd1;
    assign rx_en = (r_div == 2'd0);

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid <= n_valid + 1;
            q_data.push_back(data_out);
        end
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_flip, input int gap);
        logic p;
        p = (^d) ^ par_flip;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(p);
`endif
        drive_bit(stop_b);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int base;
        logic [7:0] f;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_busy_before_stop_end", busy, 1'b0);
        repeat (16) @(negedge clk);
        check("a5_valid_cnt", n_valid, 1);
        check("a5_data", data_out, 8'hA5);
        check("a5_ferr_cnt", n_ferr, 0);

        rx = 1'b0;
        repeat (16) @(negedge clk);
        check("glitch_busy_high", busy, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_valid_cnt", n_valid, 1);
        check("glitch_ferr_cnt", n_ferr, 0);
        check("glitch_data", data_out, 8'hA5);

        send_frame(8'h11, 1'b1, 1'b0, 64);
        check("x11_data", data_out, 8'h11);
        send_frame(8'h3C, 1'b0, 1'b0, 128);
        check("ferr_cnt", n_ferr, 1);
        check("ferr_data_kept", data_out, 8'h11);
        check("ferr_valid_cnt", n_valid, 2);
        send_frame(8'h7E, 1'b1, 1'b0, 64);
        check("x7e_valid_cnt", n_valid, 3);
        check("x7e_data", data_out, 8'h7E);

        base = q_data.size();
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 64);
        check("b2b_count", q_data.size(), base + 2);
        if (q_data.size() >= base + 2) begin
            check("b2b_first", q_data[base], 8'h00);
            check("b2b_second", q_data[base+1], 8'hFF);
        end

        base = n_valid;
        f = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(f[i]);
        rx = f[4];
        repeat (32) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", data_out, 8'h00);
        repeat (31) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(f[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^f);
`endif
        drive_bit(1'b1);
        repeat (64) @(negedge clk);
        check("midrst_no_valid", n_valid, base);
        check("midrst_ferr_cnt", n_ferr, 1);
        send_frame(8'h5A, 1'b1, 1'b0, 64);
        check("post_rst_valid", n_valid, base + 1);
        check("post_rst_data", data_out, 8'h5A);

`ifdef UART_RX_PARITY_EN
        base = n_valid;
        send_frame(8'h03, 1'b1, 1'b1, 64);
        check("par_bad_perr", n_perr, 1);
        check("par_bad_no_valid", n_valid, base);
        check("par_bad_data_kept", data_out, 8'h5A);
        send_frame(8'h03, 1'b1, 1'b0, 64);
        check("par_ok_valid", n_valid, base + 1);
        check("par_ok_data", data_out, 8'h03);
        check("par_ok_perr", n_perr, 1);
`else
        check("no_par_perr_cnt", n_perr, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8-N-1 serial frames: the receive-side counterpart of the team's UART transmitter, sharing its idle-high line convention, LSB-first data order and enable-tick timing model. The block oversamples the asynchronous `rx` line on a one-cycle baud-tick enable, validates the start bit at mid-bit, and shifts in 8 data bits. It checks the stop bit and presents each good byte with a one-cycle valid strobe. It sits between the board-level RX pin and any byte consumer, which is typically a FIFO or command parser.

## Interface
- `OVERSAMPLE`, 16: `rx_en` ticks per bit period. Must be even, minimum 4.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_en`  in  1  one-`clk` pulse at OVERSAMPLE × baud. All bit timing counts these ticks.
- `rx`  in  1  asynchronous serial input. Idle level is 1.
- `data_out`  out  8  last correctly received byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. Tied 0 unless the parity option is compiled in (see Configuration).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: two flops on `rx` produce `rx_s`. Both flops reset to 1. All logic uses `rx_s` only.
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP. All counters advance only on `rx_en`.
- IDLE: on `rx_en` with `rx_s`=0, go to START and clear the tick counter.
- START: count ticks. At tick OVERSAMPLE/2−1, sample `rx_s`:
  - 0: go to DATA and clear `bit_index`.
  - 1: treat as a glitch and return to IDLE. No error output.
- DATA: at tick OVERSAMPLE−1 (mid-bit), write `rx_s` into `shift_reg[bit_index]` (LSB first). Clear the tick counter and increment the 3-bit `bit_index`. After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP: at tick OVERSAMPLE−1, sample the stop bit, then return to IDLE.
  - Stop bit = 1: `data_out` ← `shift_reg` and pulse `data_valid`.
  - Stop bit = 0: pulse `frame_err`. `data_out` is not updated.
- Return to IDLE happens at mid-stop-bit, so a start bit immediately after the stop bit is detected.
- No buffering. `data_out` holds its value until the next good frame, so the consumer must capture it within one frame time.

## Timing
- Reset values:
  - outputs: `data_out`=0x00; `data_valid`, `frame_err`, `parity_err` = 0; `busy`=0.
  - internal: state IDLE, counters 0, synchronizer 11.
- Reset asserted mid-frame aborts the frame at the next edge. No strobe is issued.
- `busy` is combinational from the state register. It rises the `clk` after the IDLE falling-edge detect.
- Latency from the start-bit falling edge at the pin to `data_valid`: 2 `clk` (synchronizer), plus up to 1 tick for detection, plus 9.5 bit periods (10.5 with parity), plus 1 `clk` (registered strobe).
- Strobes are registered and last exactly one `clk`, regardless of `rx_en` spacing.
- `data_valid`, `frame_err` and `parity_err` never assert in the same cycle, except that `frame_err` and `parity_err` may assert together on a doubly bad frame.
- Counter widths are sized by `$clog2(OVERSAMPLE)`. `bit_index` wraps from 7 to 0 at the DATA exit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state between DATA and STOP, one bit period long, sampled at mid-bit.
  - Even parity: XOR of the 8 data bits and the parity bit must equal 0.
  - On mismatch, `parity_err` pulses in the STOP-sample cycle and `data_valid` is suppressed.
- `UART_RX_PARITY_EN` undefined: 8-N-1 framing only, and `parity_err` is held at 0.

## Test plan
- Reset, then an idle line for 100 ticks → all outputs 0, `busy`=0, `data_out`=0x00.
- Frame 0xA5 at OVERSAMPLE=16 → a single `data_valid` pulse, `data_out`=0xA5, `busy` back to 0 before the stop bit ends.
- `rx` low for 4 ticks only → START aborts to IDLE, no strobes, `data_out` unchanged.
- Frame 0x3C with stop bit 0 after a good 0x11 → `frame_err` pulses once, `data_out` stays 0x11. A following good 0x7E then yields `data_valid` with 0x7E.
- Back-to-back 0x00 then 0xFF with no idle gap → two `data_valid` pulses, values in order. Separately, `rst` pulsed during bit 4 → no strobe, IDLE, next frame received correctly.
- With `UART_RX_PARITY_EN`: 0x03 with parity bit 1 → `parity_err` pulse and no `data_valid`. 0x03 with parity bit 0 → `data_valid` and `data_out`=0x03.
